add2_chk: RTL and testbench

ADD2_CHK -- requirements
Module: add2_chk

---
 rtl/add2_pkg.sv | 22 ++
 rtl/add2_chk.sv | 145 ++++++++++++++
 tb/tb_add2_chk.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/add2_pkg.sv
// Shared definitions for the 2-bit adder checker: FSM encoding, run-length
// limit and the reference adder model.
package add2_pkg;

   localparam int unsigned NVEC_MAX = 16;
   localparam int unsigned ST_W     = 2;
   localparam int unsigned OP_W     = 2;
   localparam int unsigned SUM_W    = 3;
   localparam int unsigned VEC_W    = 2 * OP_W;

   // FSM state encoding
   localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
   localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
   localparam logic [ST_W-1:0] ST_DONE = 2'd2;

   // Reference adder: zero-extend both operands so the carry is kept (0..6)
   function automatic logic [SUM_W-1:0] ref_sum(input logic [OP_W-1:0] x,
                                                 input logic [OP_W-1:0] y);
      return SUM_W'(x) + SUM_W'(y);
   endfunction

endpackage

// File: rtl/add2_chk.sv
// add2_chk: run-based checker for a 2-bit adder under test.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   start              - begin a run (from IDLE or DONE)
//   in_valid/in_ready  - handshake for one observed vector {a,b,sum}
//   a, b, sum          - operands applied to and result from the adder
//   done, pass         - run complete / run was clean
//   err_cnt, vec_cnt   - mismatch count (saturating) and accepted vectors
//   fail_vec           - {a,b} of first mismatch, fail_seen its sticky flag
//   seq_err            - sticky flag: a vector arrived out of order
module add2_chk
   import add2_pkg::*;
#(
   parameter int unsigned NVEC = 16,
   parameter int unsigned ERRW = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   input  logic [SUM_W-1:0] sum,
   output logic             done,
   output logic             pass,
   output logic [ERRW-1:0]  err_cnt,
   output logic [ERRW-1:0]  vec_cnt,
   output logic [VEC_W-1:0] fail_vec,
   output logic             fail_seen,
   output logic             seq_err
);

   logic [ST_W-1:0]  r_state;
   logic             r_in_ready;
   logic             r_done;
   logic             r_pass;
   logic [ERRW-1:0]  r_err_cnt;
   logic [ERRW-1:0]  r_vec_cnt;
   logic [VEC_W-1:0] r_fail_vec;
   logic             r_fail_seen;
   logic             r_seq_err;

   logic [ST_W-1:0]  w_state_nxt;
   logic             w_in_ready_nxt;
   logic             w_done_nxt;
   logic             w_pass_nxt;
   logic [ERRW-1:0]  w_err_cnt_nxt;
   logic [ERRW-1:0]  w_vec_cnt_nxt;
   logic [VEC_W-1:0] w_fail_vec_nxt;
   logic             w_fail_seen_nxt;
   logic             w_seq_err_nxt;

   logic             w_xfer;
   logic             w_enter_run;
   logic             w_mismatch;
   logic             w_out_of_order;
   logic             w_last;
   logic [VEC_W-1:0] w_ab;

   assign w_ab = {a, b};

   // r_in_ready mirrors (state == RUN), so it doubles as the transfer gate
   assign w_xfer         = in_valid & r_in_ready;
   assign w_enter_run    = start & (r_state != ST_RUN);
   assign w_mismatch     = w_xfer & (ref_sum(a, b) != sum);
   assign w_out_of_order = w_xfer & (w_ab != r_vec_cnt[VEC_W-1:0]);
   assign w_last         = w_xfer & ((r_vec_cnt + ERRW'(1)) == ERRW'(NVEC));

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_err_cnt_nxt   = r_err_cnt;
      w_vec_cnt_nxt   = r_vec_cnt;
      w_fail_vec_nxt  = r_fail_vec;
      w_fail_seen_nxt = r_fail_seen;
      w_seq_err_nxt   = r_seq_err;

      case (r_state)
         ST_IDLE: if (start)  w_state_nxt = ST_RUN;
         ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
         ST_DONE: if (start)  w_state_nxt = ST_RUN;
         default:             w_state_nxt = ST_IDLE;
      endcase

      if (w_enter_run) begin
         // A new run starts from a clean slate on the same edge
         w_err_cnt_nxt   = '0;
         w_vec_cnt_nxt   = '0;
         w_fail_vec_nxt  = '0;
         w_fail_seen_nxt = 1'b0;
         w_seq_err_nxt   = 1'b0;
      end else if (w_xfer) begin
         w_vec_cnt_nxt = r_vec_cnt + ERRW'(1);
         if (w_mismatch) begin
            if (r_err_cnt != '1) w_err_cnt_nxt = r_err_cnt + ERRW'(1);
            if (!r_fail_seen) begin
               w_fail_vec_nxt  = w_ab;
               w_fail_seen_nxt = 1'b1;
            end
         end
         if (w_out_of_order) w_seq_err_nxt = 1'b1;
      end

      // Verdict uses the post-update values so the last vector is included
      w_in_ready_nxt = (w_state_nxt == ST_RUN);
      w_done_nxt     = (w_state_nxt == ST_DONE);
      w_pass_nxt     = w_done_nxt && (w_err_cnt_nxt == '0) && !w_seq_err_nxt;
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_in_ready  <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_cnt   <= '0;
         r_vec_cnt   <= '0;
         r_fail_vec  <= '0;
         r_fail_seen <= 1'b0;
         r_seq_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= w_in_ready_nxt;
         r_done      <= w_done_nxt;
         r_pass      <= w_pass_nxt;
         r_err_cnt   <= w_err_cnt_nxt;
         r_vec_cnt   <= w_vec_cnt_nxt;
         r_fail_vec  <= w_fail_vec_nxt;
         r_fail_seen <= w_fail_seen_nxt;
         r_seq_err   <= w_seq_err_nxt;
      end
   end

   assign in_ready  = r_in_ready;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_cnt   = r_err_cnt;
   assign vec_cnt   = r_vec_cnt;
   assign fail_vec  = r_fail_vec;
   assign fail_seen = r_fail_seen;
   assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_add2_chk.sv
// Scoreboard bench for add2_chk: each run pushes its hand-computed verdict,
// a monitor pops and compares whenever done rises.
module tb_add2_chk;

   localparam int unsigned ERRW = 5;
   localparam int unsigned NVEC = 16;

   logic             clk;
   logic             rst;
   logic             start;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       a;
   logic [1:0]       b;
   logic [2:0]       sum;
   logic             done;
   logic             pass;
   logic [ERRW-1:0]  err_cnt;
   logic [ERRW-1:0]  vec_cnt;
   logic [3:0]       fail_vec;
   logic             fail_seen;
   logic             seq_err;

   typedef struct {
      int pass;
      int err;
      int vec;
      int fv;
      int fs;
      int se;
   } exp_t;

   exp_t q[$];
   int   n_total  = 0;
   int   n_passed = 0;
   logic prev_done = 1'b0;

   add2_chk #(.NVEC(NVEC), .ERRW(ERRW)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .a(a), .b(b), .sum(sum), .done(done),
      .pass(pass), .err_cnt(err_cnt), .vec_cnt(vec_cnt),
      .fail_vec(fail_vec), .fail_seen(fail_seen), .seq_err(seq_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_passed++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Monitor: one verdict per rising done
   always @(negedge clk) begin
      if (done && !prev_done) begin
         if (q.size() == 0) begin
            chk("sb_unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("sb_pass",      int'(pass),      e.pass);
            chk("sb_err_cnt",   int'(err_cnt),   e.err);
            chk("sb_vec_cnt",   int'(vec_cnt),   e.vec);
            chk("sb_fail_vec",  int'(fail_vec),  e.fv);
            chk("sb_fail_seen", int'(fail_seen), e.fs);
            chk("sb_seq_err",   int'(seq_err),   e.se);
         end
      end
      prev_done <= done;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Present one vector and hold it until accepted (bounded)
   task automatic send(input logic [1:0] ta, input logic [1:0] tb_,
                       input logic [2:0] ts);
      int n   = 0;
      bit got = 1'b0;
      a = ta; b = tb_; sum = ts; in_valid = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk);
         got = in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      if (!got) chk("xfer_timeout", 0, 1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_done"},      int'(done),      0);
      chk({tag, "_pass"},      int'(pass),      0);
      chk({tag, "_in_ready"},  int'(in_ready),  0);
      chk({tag, "_err_cnt"},   int'(err_cnt),   0);
      chk({tag, "_vec_cnt"},   int'(vec_cnt),   0);
      chk({tag, "_fail_vec"},  int'(fail_vec),  0);
      chk({tag, "_fail_seen"}, int'(fail_seen), 0);
      chk({tag, "_seq_err"},   int'(seq_err),   0);
   endtask

   // mode 0: clean, 1: sum forced to 0 at vectors 5 and 11, 2: vectors 2/3 swapped
   task automatic do_run(input int mode, input bit push, input bit do_start,
                         input bit gaps, input int nsend);
      exp_t e;
      if (push) begin
         case (mode)
            1:       e = '{pass: 0, err: 2, vec: 16, fv: 5, fs: 1, se: 0};
            2:       e = '{pass: 0, err: 0, vec: 16, fv: 0, fs: 0, se: 1};
            default: e = '{pass: 1, err: 0, vec: 16, fv: 0, fs: 0, se: 0};
         endcase
         q.push_back(e);
      end
      if (do_start) pulse_start();
      for (int i = 0; i < nsend; i++) begin
         int         idx;
         logic [3:0] v;
         logic [2:0] s;
         idx = i;
         if (mode == 2 && i == 2) idx = 3;
         if (mode == 2 && i == 3) idx = 2;
         v = 4'(idx);
         s = 3'(v[3:2]) + 3'(v[1:0]);
         if (mode == 1 && (idx == 5 || idx == 11)) s = 3'd0;
         send(v[3:2], v[1:0], s);
         if (gaps && i != nsend - 1) tick();
      end
      if (nsend == int'(NVEC)) chk("done_latency", int'(done), 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      a = 2'd0; b = 2'd0; sum = 3'd0;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // in_valid in IDLE must not count, and no transfer before start
      a = 2'd0; b = 2'd0; sum = 3'd0; in_valid = 1'b1;
      repeat (4) tick();
      in_valid = 1'b0;
      chk("idle_vec_cnt", int'(vec_cnt), 0);
      chk("idle_in_ready", int'(in_ready), 0);

      // Contiguous clean sweep
      do_run(0, 1'b1, 1'b1, 1'b0, 16);

      // in_valid while DONE is ignored
      in_valid = 1'b1; a = 2'd3; b = 2'd3; sum = 3'd0;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("done_vec_cnt", int'(vec_cnt), 16);
      chk("done_err_cnt", int'(err_cnt), 0);
      chk("done_hold", int'(done), 1);

      // Gapped clean sweep
      do_run(0, 1'b1, 1'b1, 1'b1, 16);

      // Faulty sweep
      do_run(1, 1'b1, 1'b1, 1'b0, 16);
      tick();

      // Restart from DONE: everything cleared on the start edge
      begin
         exp_t e;
         e = '{pass: 1, err: 0, vec: 16, fv: 0, fs: 0, se: 0};
         q.push_back(e);
      end
      pulse_start();
      chk("restart_err_cnt",   int'(err_cnt),   0);
      chk("restart_vec_cnt",   int'(vec_cnt),   0);
      chk("restart_fail_vec",  int'(fail_vec),  0);
      chk("restart_fail_seen", int'(fail_seen), 0);
      chk("restart_done",      int'(done),      0);
      chk("restart_pass",      int'(pass),      0);
      chk("restart_in_ready",  int'(in_ready),  1);
      do_run(0, 1'b0, 1'b0, 1'b0, 16);

      // Out-of-order sweep
      do_run(2, 1'b1, 1'b1, 1'b0, 16);

      // Reset mid-run after 7 transfers
      do_run(0, 1'b0, 1'b1, 1'b0, 7);
      chk("midrun_vec_cnt", int'(vec_cnt), 7);
      #2 rst = 1'b1;
      #1 check_all_zero("midrun_rst");
      tick();
      rst = 1'b0;
      in_valid = 1'b1; a = 2'd0; b = 2'd0; sum = 3'd0;
      repeat (3) tick();
      in_valid = 1'b0;
      chk("post_rst_vec_cnt", int'(vec_cnt), 0);
      do_run(0, 1'b1, 1'b1, 1'b0, 16);

      repeat (3) tick();
      chk("sb_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
